// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, writeback mux, register-file write port, WB->ID forwarding,
// sticky halt and retired counter. Define WB_FORWARD_EN to build the forwarding logic.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_wrEn,
    input  logic [2:0]  in_wrReg,
    input  logic [1:0]  in_wbSel,
    input  logic [15:0] in_aluRes,
    input  logic [15:0] in_memData,
    input  logic [15:0] in_pcInc,
    input  logic        in_halt,
    input  logic [2:0]  id_read1regsel,
    input  logic [2:0]  id_read2regsel,
    output logic        write,
    output logic [2:0]  writeregsel,
    output logic [15:0] writedata,
    output logic        bypass,
    output logic        bypassReg,
    output logic        dual_hit,
    output logic        halt,
    output logic [15:0] retired,
    output logic        err
);

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC  = 2'b10;
    localparam logic [1:0] SEL_RSV = 2'b11;

    logic        valid_r;
    logic        wren_r;
    logic [2:0]  wrreg_r;
    logic [1:0]  wbsel_r;
    logic [15:0] alures_r;
    logic [15:0] memdata_r;
    logic [15:0] pcinc_r;
    logic        haltflag_r;
    logic        done_r;
    logic        halted_r;
    logic [15:0] retired_r;

    logic        commit_s;
    logic        write_s;
    logic [15:0] wdata_s;

    assign commit_s = valid_r & ~done_r & ~halted_r;
    assign write_s  = commit_s & wren_r & (wbsel_r != SEL_RSV);

    // MEM/WB register, halt latch and retired counter; done marks an entry already committed
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r    <= 1'b0;
            wren_r     <= 1'b0;
            wrreg_r    <= 3'd0;
            wbsel_r    <= 2'b00;
            alures_r   <= 16'h0000;
            memdata_r  <= 16'h0000;
            pcinc_r    <= 16'h0000;
            haltflag_r <= 1'b0;
            done_r     <= 1'b0;
            halted_r   <= 1'b0;
            retired_r  <= 16'h0000;
        end else begin
            if (commit_s) begin
                retired_r <= retired_r + 16'd1;
            end
            if (commit_s && haltflag_r) begin
                halted_r <= 1'b1;
            end
            if (!halted_r) begin
                if (flush) begin
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                end else if (stall) begin
                    done_r  <= valid_r;
                end else begin
                    valid_r    <= in_valid;
                    wren_r     <= in_wrEn;
                    wrreg_r    <= in_wrReg;
                    wbsel_r    <= in_wbSel;
                    alures_r   <= in_aluRes;
                    memdata_r  <= in_memData;
                    pcinc_r    <= in_pcInc;
                    haltflag_r <= in_halt;
                    done_r     <= 1'b0;
                end
            end
        end
    end

    // Writeback source select; the reserved encoding yields zero
    always_comb begin
        wdata_s = 16'h0000;
        case (wbsel_r)
            SEL_ALU: wdata_s = alures_r;
            SEL_MEM: wdata_s = memdata_r;
            SEL_PC:  wdata_s = pcinc_r;
            default: wdata_s = 16'h0000;
        endcase
    end

    assign write       = write_s;
    assign writeregsel = wrreg_r;
    assign writedata   = wdata_s;
    assign halt        = halted_r;
    assign retired     = retired_r;
    assign err         = valid_r & (wbsel_r == SEL_RSV);

`ifdef WB_FORWARD_EN
    logic m1_s;
    logic m2_s;
    logic bypass_s;
    logic bypassreg_s;
    logic dual_s;

    assign m1_s = (id_read1regsel == wrreg_r);
    assign m2_s = (id_read2regsel == wrreg_r);

    // Forward to port 1 when it matches, else port 2; a double match asks decode to stall
    always_comb begin
        bypass_s    = 1'b0;
        bypassreg_s = 1'b0;
        dual_s      = 1'b0;
        if (write_s) begin
            if (m1_s) begin
                bypass_s    = 1'b1;
                bypassreg_s = 1'b0;
                dual_s      = m2_s;
            end else if (m2_s) begin
                bypass_s    = 1'b1;
                bypassreg_s = 1'b1;
                dual_s      = 1'b0;
            end else begin
                bypass_s    = 1'b0;
                bypassreg_s = 1'b0;
                dual_s      = 1'b0;
            end
        end else begin
            bypass_s    = 1'b0;
            bypassreg_s = 1'b0;
            dual_s      = 1'b0;
        end
    end

    assign bypass    = bypass_s;
    assign bypassReg = bypassreg_s;
    assign dual_hit  = dual_s;
`else
    logic unused_s;
    assign unused_s  = ^{id_read1regsel, id_read2regsel};
    assign bypass    = 1'b0;
    assign bypassReg = 1'b0;
    assign dual_hit  = 1'b0;
`endif

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 16-bit, 8-register five-stage pipeline. It holds the MEM/WB pipeline register, selects the writeback value, and drives the register file write port `write`/`writeregsel`/`writedata`. It compares the write target against the decode-stage read selects to produce the register file's `bypass`/`bypassReg` controls. It also provides sticky halt detection and a retired-instruction counter.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  pipeline clock, all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `stall`  in  1  global pipeline freeze; WB register holds its contents
- `flush`  in  1  loads a bubble (valid=0) into the WB register; priority over `stall`
- `in_valid`  in  1  MEM stage presents a real instruction
- `in_wrEn`  in  1  instruction writes a register
- `in_wrReg`  in  3  destination register
- `in_wbSel`  in  2  writeback source: 00 ALU, 01 memory, 10 PC+2, 11 reserved
- `in_aluRes`  in  16  ALU result
- `in_memData`  in  16  memory read data
- `in_pcInc`  in  16  PC+2 (link value)
- `in_halt`  in  1  instruction is HALT
- `id_read1regsel`, `id_read2regsel`  in  3 each  decode-stage read selects
- `write`  out  1  register file write enable
- `writeregsel`  out  3  register file write select
- `writedata`  out  16  register file write data
- `bypass`  out  1  forward `writedata` to one decode read port
- `bypassReg`  out  1  0 = forward to read port 1, 1 = forward to read port 2
- `dual_hit`  out  1  both decode read selects match the active write; decode must stall one cycle
- `halt`  out  1  sticky halt
- `retired`  out  16  count of committed instructions
- `err`  out  1  valid entry with reserved `in_wbSel`

## Operation
- WB register fields: valid, wrEn, wrReg, wbSel, aluRes, memData, pcInc, haltFlag, plus internal `done` bit.
- Load priority per cycle: `rst` > `halted` (freeze) > `flush` (valid=0, done=0) > `stall` (hold; done<=valid) > normal load (done=0).
- Commit condition `commit = valid & ~done & ~halted`.
- `write = commit & wrEn & (wbSel != 11)`; `writeregsel = wrReg`; `writedata` = mux(wbSel); reserved select drives `writedata` 0.
- A stalled entry commits exactly once. Its first cycle has done=0; later stalled cycles have done=1 and `write`=0.
- `err = valid & (wbSel == 11)`. It is combinational and does not affect the counter.
- Forwarding, only while `write`=1:
  - m1 = (`id_read1regsel`==`wrReg`), m2 = (`id_read2regsel`==`wrReg`).
  - m1 only: bypass=1, bypassReg=0.
  - m2 only: bypass=1, bypassReg=1.
  - m1&m2: bypass=1, bypassReg=0, `dual_hit`=1.
  - Otherwise bypass=0, bypassReg=0.
- Halt: when `commit & haltFlag`, `halted` is set at the next edge and `halt`=1 until `rst`. The HALT itself counts as retired. While halted, the register freezes and no writes occur.
- `retired` increments by 1 on each edge with `commit`=1, wrapping 0xFFFF -> 0x0000.

## Timing
- Inputs are captured on the edge, and outputs are valid in the following cycle. Writeback latency is 1 cycle from MEM.
- `write`/`writedata`/`bypass` are combinational from WB state, so the register file writes at the same edge that the next WB entry loads.
- Reset values: all outputs 0; valid=0, done=0, halted=0, retired=0x0000.
- `rst` asserted mid-stall or while halted clears everything in the same edge.
- `flush` and `stall` together: flush wins.

## Configuration
- `WB_FORWARD_EN` defined: forwarding logic present as above.
- Not defined: `bypass`, `bypassReg`, `dual_hit` are tied to 0. Decode resolves WB hazards by stalling.

## Test plan
- Reset, then ALU op r3 := 0x1234, wbSel=00 -> next cycle write=1, writeregsel=3, writedata=0x1234, retired=1.
- Load r5 with memData=0xBEEF, `id_read2regsel`=5, `id_read1regsel`=2 -> bypass=1, bypassReg=1, dual_hit=0; with read1=read2=5 -> bypassReg=0, dual_hit=1.
- Valid write entry followed by stall for 3 cycles -> write=1 in the first cycle only, retired increments by exactly 1.
- flush and stall both asserted with in_valid=1 -> WB valid=0, write=0, retired unchanged.
- HALT committed, then further valid inputs -> halt=1 stays high, write=0 thereafter, retired frozen; `rst` clears halt and retired.
- Preload retired to 0xFFFF via 65535 commits, then one more commit -> retired=0x0000. wbSel=11 entry -> err=1, write=0.
